// File: rtl/pipeline_pkg.sv
// Shared constants for the e = ((a+b)+(c-d))*d pipeline and its result buffer.
package pipeline_pkg;

    localparam int PIPE_DATA_W    = 32;
    localparam int PIPE_LATENCY   = 3;
    localparam int RES_FIFO_DEPTH = 4;

    function automatic int unsigned popcount(input logic [31:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < 32; i++) begin
            n += {31'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/pipe_sync_fifo.sv
// Show-ahead synchronous FIFO; a write while full is accepted only alongside a pop.
module pipe_sync_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic                     rd_en,
    input  logic [DATA_W-1:0]        din,
    output logic [DATA_W-1:0]        dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_wr;
    logic              do_rd;

    assign empty = (count == '0);
    assign full  = (count == FULL_CNT);
    assign do_rd = rd_en && !empty;
    assign do_wr = wr_en && (!full || do_rd);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage carries data only, so it is left out of reset.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= din;
    end

    assign dout = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/pipeline_result_buffer.sv
// Tracks issued operand sets through the stall-free arithmetic pipeline and
// buffers each emerging result behind a ready/valid port with credit-based issue.
module pipeline_result_buffer
    import pipeline_pkg::*;
#(
    parameter int DATA_W  = PIPE_DATA_W,
    parameter int LATENCY = PIPE_LATENCY,
    parameter int DEPTH   = RES_FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     issue_valid,
    output logic                     issue_ready,
    input  logic [DATA_W-1:0]        pipe_e,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [DATA_W-1:0]        res_data,
    output logic [$clog2(DEPTH):0]   res_count,
    output logic                     ovf_err
);

    logic [LATENCY-1:0] vld_sr;
    logic               accept;
    logic               wr_req;
    logic               pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [31:0]        occupied;

    assign wr_req    = vld_sr[LATENCY-1];
    assign res_valid = !fifo_empty;
    assign pop       = res_valid && res_ready;
    assign accept    = issue_valid && issue_ready;

    // A pop this cycle frees its slot long before a newly issued result can
    // arrive, so counting it keeps one-result-per-cycle streaming at DEPTH=LATENCY+1.
    always_comb begin
        occupied    = 32'(res_count) + popcount(32'(vld_sr)) - {31'd0, pop};
        issue_ready = !rst && (occupied < 32'(DEPTH));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_sr  <= '0;
            ovf_err <= 1'b0;
        end else begin
            vld_sr <= {vld_sr[LATENCY-2:0], accept};
            if (wr_req && fifo_full && !pop) ovf_err <= 1'b1;
        end
    end

    pipe_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .wr_en (wr_req),
        .rd_en (pop),
        .din   (pipe_e),
        .dout  (res_data),
        .count (res_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule
